// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: state encoding, status bundle and
// the constants that size the loader datapath.
package prog_loader_pkg;

  localparam int IA_BITS                 = 8;
  localparam int PROG_LOADER_INSTR_WIDTH = 16;
  localparam int PROG_LOADER_COUNT_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_CHECK   = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } loaderState_e;

  typedef struct packed {
    logic busy;
    logic done;
    logic error;
    logic coreRstn;
    logic rxReady;
  } loaderStatus_t;

  // Status flags are a pure function of the state they will accompany.
  function automatic loaderStatus_t statusFor(loaderState_e s);
    loaderStatus_t st;
    st = '0;
    case (s)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK: begin
        st.busy    = 1'b1;
        st.rxReady = 1'b1;
      end
      S_DONE: begin
        st.done     = 1'b1;
        st.coreRstn = 1'b1;
      end
      S_ERROR: st.error = 1'b1;
      default: ;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/prog_loader_checksum.sv
// Running XOR over the received program bytes; cleared when a new load starts.
module ldr_checksum (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clear,
  input  logic       byteEn,
  input  logic [7:0] data,
  output logic [7:0] sum
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum <= 8'd0;
    end else if (clear) begin
      sum <= 8'd0;
    end else if (byteEn) begin
      sum <= sum ^ data;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: receives count, 16-bit words and a checksum,
// writes the words into instruction memory and releases the core on success.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int pc_width    = IA_BITS,
  parameter int instr_width = PROG_LOADER_INSTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   imem_we,
  output logic [pc_width-1:0]    imem_addr,
  output logic [instr_width-1:0] imem_wdata,
  output logic                   core_rstn,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output loaderState_e           dbgState
);

  localparam logic [PROG_LOADER_COUNT_WIDTH:0] maxCount =
    (PROG_LOADER_COUNT_WIDTH+1)'(1) << pc_width;

  loaderState_e                       state;
  loaderState_e                       stateNext;
  loaderStatus_t                      status;
  logic [PROG_LOADER_COUNT_WIDTH-1:0] count;
  logic [PROG_LOADER_COUNT_WIDTH-1:0] index;
  logic [7:0]                         hiByte;
  logic [7:0]                         checksum;
  logic                               xfer;
  logic                               startTaken;
  logic                               idleLike;

  // Handshake: a byte moves only on a rising edge where rx_valid and rx_ready
  // are both high; rx_valid may drop at any time and simply stalls the loader.
  assign xfer       = rx_valid && rx_ready;
  assign idleLike   = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign startTaken = start && idleLike;

  ldr_checksum uChecksum (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (startTaken),
    .byteEn (xfer && (state != S_CHECK)),
    .data   (rx_data),
    .sum    (checksum)
  );

  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) stateNext = S_LEN_HI;
      S_LEN_HI: if (xfer) stateNext = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if ({1'b0, count[15:8], rx_data} > maxCount) stateNext = S_ERROR;
          else if ({count[15:8], rx_data} == 16'd0)     stateNext = S_CHECK;
          else                                          stateNext = S_DATA_HI;
        end
      end
      S_DATA_HI: if (xfer) stateNext = S_DATA_LO;
      S_DATA_LO: if (xfer) stateNext = ((index + 16'd1) == count) ? S_CHECK : S_DATA_HI;
      S_CHECK:   if (xfer) stateNext = (rx_data == checksum) ? S_DONE : S_ERROR;
      default:   stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      status     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      count      <= '0;
      index      <= '0;
      hiByte     <= 8'd0;
    end else begin
      state   <= stateNext;
      status  <= statusFor(stateNext);
      imem_we <= 1'b0;
      if (startTaken) begin
        count <= '0;
        index <= '0;
      end
      if (xfer) begin
        case (state)
          S_LEN_HI:  count[15:8] <= rx_data;
          S_LEN_LO:  count[7:0]  <= rx_data;
          S_DATA_HI: hiByte      <= rx_data;
          S_DATA_LO: begin
            imem_we    <= 1'b1;
            imem_addr  <= index[pc_width-1:0];
            imem_wdata <= {hiByte, rx_data};
            index      <= index + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_ready  = status.rxReady;
  assign busy      = status.busy;
  assign done      = status.done;
  assign error     = status.error;
  assign core_rstn = status.coreRstn;
  assign dbgState  = state;

endmodule
